// File: rtl/crc32_d16_rx_check.sv
`default_nettype none
// ============================================================================
// Module   : crc32_d16_rx_check
// Brief    : Receive-side CRC-32 FCS checker for a framed 16-bit MAC datapath.
// Revision : 1.0 - initial release
// ============================================================================
module crc32_d16_rx_check #(
    parameter logic [31:0] RESIDUE = 32'hC704DD7B,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             in_odd,
    input  logic [15:0]      in_data,
    output logic             stat_valid,
    output logic             stat_ok,
    output logic             stat_runt,
    output logic [15:0]      stat_len,
    output logic             proto_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [31:0] c_POLY = 32'h04C11DB7;
    localparam logic [31:0] c_INIT = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_IN_FRAME = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_crc;
    logic [15:0] r_len;

    logic        w_start, w_cont, w_accept, w_abort, w_final, w_half;
    logic [31:0] w_crc_base, w_crc_nxt;
    logic [15:0] w_len_base, w_len_nxt;
    logic [16:0] w_len_sum;
    logic        w_runt, w_ok, w_perr;
    logic        w_stat_fire, w_stat_ok, w_stat_runt;
    logic [15:0] w_stat_len;

    // MSB-first, non-reflected byte update
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ b[i];
            c  = {c[30:0], 1'b0} ^ (fb ? c_POLY : 32'h0);
        end
        return c;
    endfunction

    always_comb begin
        w_start     = in_valid & in_sop;
        w_cont      = in_valid & ~in_sop & (r_state == S_IN_FRAME);
        w_accept    = w_start | w_cont;
        w_abort     = w_start & (r_state == S_IN_FRAME);
        w_final     = w_accept & in_eop;
        w_half      = in_eop & in_odd;

        w_crc_base  = w_start ? c_INIT : r_crc;
        w_len_base  = w_start ? 16'd0 : r_len;
        w_crc_nxt   = w_half ? crc_byte(w_crc_base, in_data[15:8])
                             : crc_byte(crc_byte(w_crc_base, in_data[15:8]), in_data[7:0]);
        w_len_sum   = {1'b0, w_len_base} + (w_half ? 17'd1 : 17'd2);
        w_len_nxt   = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

        w_runt      = (w_len_nxt < 16'd5);
        w_ok        = (w_crc_nxt == RESIDUE) & ~w_runt;
        w_perr      = (in_valid & ~in_sop & (r_state == S_IDLE))
                    | w_abort
                    | (in_valid & in_odd & ~in_eop);

        // An abort reports the frame that was open; its bytes are already in r_len.
        w_stat_fire = w_abort | w_final;
        w_stat_ok   = w_abort ? 1'b0 : w_ok;
        w_stat_runt = w_abort ? (r_len < 16'd5) : w_runt;
        w_stat_len  = w_abort ? r_len : w_len_nxt;

        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = in_eop ? S_IDLE : S_IN_FRAME;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_crc      <= c_INIT;
            r_len      <= 16'd0;
            stat_valid <= 1'b0;
            stat_ok    <= 1'b0;
            stat_runt  <= 1'b0;
            stat_len   <= 16'd0;
            proto_err  <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            stat_valid <= w_stat_fire;
            proto_err  <= w_perr;
            if (w_accept) begin
                r_crc <= w_crc_nxt;
                r_len <= w_len_nxt;
            end
            if (w_stat_fire) begin
                stat_ok   <= w_stat_ok;
                stat_runt <= w_stat_runt;
                stat_len  <= w_stat_len;
                if (w_stat_ok) begin
                    if (good_cnt != {CNT_W{1'b1}}) good_cnt <= good_cnt + 1'b1;
                end else begin
                    if (bad_cnt != {CNT_W{1'b1}}) bad_cnt <= bad_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc32_d16_rx_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc32_d16_rx_check
// Brief    : Randomised self-checking bench with a byte-queue CRC reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc32_d16_rx_check;

    localparam int          CNT_W   = 4;
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;
    localparam int unsigned CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_odd = 1'b0;
    logic [15:0]      in_data = 16'h0;
    logic             stat_valid, stat_ok, stat_runt, proto_err;
    logic [15:0]      stat_len;
    logic [CNT_W-1:0] good_cnt, bad_cnt;

    crc32_d16_rx_check #(.RESIDUE(RESIDUE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_odd(in_odd), .in_data(in_data),
        .stat_valid(stat_valid), .stat_ok(stat_ok), .stat_runt(stat_runt), .stat_len(stat_len),
        .proto_err(proto_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic        ok;
        logic        runt;
        logic [15:0] len;
        logic        abort;
    } stat_t;

    stat_t        sq[$];
    int unsigned  pq[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [31:0]  tbl[256];
    byte unsigned fb[$];
    bit           open = 0;
    int unsigned  good_m = 0, bad_m = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc_of(input byte unsigned b[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (b[i]) c = (c << 8) ^ tbl[c[31:24] ^ b[i]];
        return c;
    endfunction

    function automatic logic [15:0] sat16(input int unsigned n);
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    // One input cycle; the reference model decides which status / error it owes next cycle.
    task automatic drive(input bit v, input bit s, input bit e, input bit o, input logic [15:0] d);
        stat_t st;
        bit    perr;
        @(negedge clk);
        in_valid = v; in_sop = s; in_eop = e; in_odd = o; in_data = d;
        if (v) begin
            perr   = (o && !e);
            st.due = cyc + 1;
            if (!open && !s) begin
                perr = 1;
            end else begin
                if (s && open) begin
                    perr = 1;
                    st.ok = 0; st.runt = 0; st.len = sat16(fb.size()); st.abort = 1;
                    sq.push_back(st);
                end
                if (s) begin
                    fb.delete();
                    open = 1;
                end
                fb.push_back(d[15:8]);
                if (!(e && o)) fb.push_back(d[7:0]);
                if (e) begin
                    st.len   = sat16(fb.size());
                    st.runt  = (fb.size() < 5);
                    st.ok    = (crc_of(fb) == RESIDUE) && !st.runt;
                    st.abort = 0;
                    sq.push_back(st);
                    open = 0;
                end
            end
            if (perr) pq.push_back(st.due);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 16'($urandom));
    endtask

    task automatic send_frame(input byte unsigned b[$], input bit bub);
        int n = b.size();
        for (int i = 0; i < n; i += 2) begin
            bit          last = (i + 2 >= n);
            bit          odd  = (i + 1 == n);
            logic [15:0] d;
            if (bub && ($urandom % 4 == 0)) drive(0, 0, 0, 0, 16'($urandom));
            d[15:8] = b[i];
            d[7:0]  = odd ? 8'($urandom) : b[i+1];
            drive(1, i == 0, last, odd, d);
        end
    endtask

    task automatic make_frame(input int payload, output byte unsigned q[$]);
        logic [31:0] fcs;
        q.delete();
        for (int i = 0; i < payload; i++) q.push_back(8'($urandom));
        fcs = ~crc_of(q);
        for (int k = 3; k >= 0; k--) q.push_back(fcs[8*k +: 8]);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst = 0; in_valid = 0;
        open = 0; fb.delete();
        @(negedge clk);
        rst = 1;
    endtask

    // Output monitor: samples just after each active edge.
    always @(posedge clk) begin
        stat_t e;
        #1;
        if (!rst) begin
            sq.delete(); pq.delete();
            good_m = 0; bad_m = 0;
            check_val("rst_stat_valid", stat_valid, 0);
            check_val("rst_proto_err", proto_err, 0);
        end else begin
            while (sq.size() > 0 && sq[0].due < cyc) begin
                check_val("stat_missing", 0, 1);
                e = sq.pop_front();
            end
            while (pq.size() > 0 && pq[0] < cyc) begin
                check_val("proto_missing", 0, 1);
                void'(pq.pop_front());
            end
            if (sq.size() > 0 && sq[0].due == cyc) begin
                e = sq.pop_front();
                check_val("stat_valid", stat_valid, 1);
                check_val("stat_ok", stat_ok, e.ok);
                check_val("stat_len", stat_len, e.len);
                if (!e.abort) check_val("stat_runt", stat_runt, e.runt);
                if (e.ok) good_m = (good_m == CMAX) ? CMAX : good_m + 1;
                else      bad_m  = (bad_m  == CMAX) ? CMAX : bad_m + 1;
            end else begin
                check_val("stat_unexpected", stat_valid, 0);
            end
            if (pq.size() > 0 && pq[0] == cyc) begin
                void'(pq.pop_front());
                check_val("proto_err", proto_err, 1);
            end else begin
                check_val("proto_unexpected", proto_err, 0);
            end
        end
        check_val("good_cnt", good_cnt, good_m);
        check_val("bad_cnt", bad_cnt, bad_m);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned q[$], g13[$], bad13[$], big[$];
        logic [31:0]  c;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i) << 24;
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
            tbl[i] = c;
        end
        g13 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'hFC, 8'h89, 8'h19, 8'h18};
        bad13 = g13;
        bad13[3] = bad13[3] ^ 8'h01;

        repeat (3) @(negedge clk);
        check_val("rst_stat_ok", stat_ok, 0);
        check_val("rst_stat_runt", stat_runt, 0);
        check_val("rst_stat_len", stat_len, 0);
        rst = 1;
        idle(2);

        // Known-good 13-byte frame, then the same frame with one bit flipped.
        send_frame(g13, 0);  idle(2);
        send_frame(bad13, 0); idle(2);

        // 64-byte frame followed immediately by the 13-byte frame.
        make_frame(60, q);
        send_frame(q, 0); send_frame(g13, 0); idle(2);

        // Single-beat runt.
        drive(1, 1, 1, 0, 16'h0000); idle(2);

        // Abort after three beats, new frame starts on the sop beat.
        drive(1, 1, 0, 0, 16'h3132); drive(1, 0, 0, 0, 16'h3334); drive(1, 0, 0, 0, 16'h3536);
        send_frame(g13, 0); idle(2);

        // Stray beat while idle.
        drive(1, 0, 0, 0, 16'hABCD); idle(2);

        // Odd flag on a non-eop beat is treated as a full beat.
        drive(1, 1, 0, 0, 16'h3132); drive(1, 0, 0, 1, 16'h3334);
        drive(1, 0, 0, 0, 16'h3536); drive(1, 0, 0, 0, 16'h3738);
        drive(1, 0, 0, 0, 16'h39FC); drive(1, 0, 0, 0, 16'h8919); drive(1, 0, 1, 1, 16'h1800);
        idle(2);

        // Reset in the middle of a frame.
        drive(1, 1, 0, 0, 16'h1111); drive(1, 0, 0, 0, 16'h2222);
        reset_cycle();
        idle(2);

        // Randomised frames: good, corrupted and runts, with gaps and bubbles.
        for (int n = 0; n < 40; n++) begin
            int kind = $urandom % 5;
            if (kind == 0) begin
                q.delete();
                for (int i = 0; i < 1 + $urandom % 4; i++) q.push_back(8'($urandom));
            end else begin
                make_frame($urandom % 61, q);
                if (kind == 1) begin
                    int p = $urandom % q.size();
                    q[p] = q[p] ^ (8'h01 << ($urandom % 8));
                end
            end
            send_frame(q, 1);
            idle($urandom % 3);
        end

        // Counter saturation: enough good and bad frames to pass all-ones.
        for (int n = 0; n < 18; n++) begin
            send_frame(bad13, 0);
            send_frame(g13, 0);
        end
        idle(2);

        // Length saturation on a very long frame.
        make_frame(65540, big);
        send_frame(big, 0);
        idle(4);

        check_val("stat_drained", sq.size(), 0);
        check_val("proto_drained", pq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
